// File: rtl/fetch_unit_pkg.sv
// YASAC fetch stage shared definitions: widths, FSM encoding, instruction fields.
package fetch_unit_pkg;

    localparam int unsigned ADDR_W_DEF  = 8;
    localparam int unsigned INSTR_W_DEF = 16;
    localparam logic [7:0]  RESET_PC_DEF = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

    localparam int unsigned OPC_MSB = 15;
    localparam int unsigned OPC_LSB = 11;
    localparam int unsigned RA_MSB  = 10;
    localparam int unsigned RA_LSB  = 8;
    localparam int unsigned K_MSB   = 7;
    localparam int unsigned K_LSB   = 0;
    localparam int unsigned RB_MSB  = 2;
    localparam int unsigned RB_LSB  = 0;

    function automatic logic [4:0] opcode_of(input logic [15:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/fetch_unit_pc_counter.sv
// Program counter: sync reset, load, increment with natural wrap, hold.
module fetch_unit_pc_counter
    import fetch_unit_pkg::*;
#(
    parameter int unsigned       ADDR_W    = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_val_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i;
        end else if (inc_i) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            pc_q <= RESET_VAL;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// YASAC instruction fetch stage: PC, IR and valid/ready hand-off to decode.
// Optional transfer counter output fetch_cnt enabled by YASAC_FETCH_CNT_EN.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned       ADDR_W   = ADDR_W_DEF,
    parameter int unsigned       INSTR_W  = INSTR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               halt,
    output logic [ADDR_W-1:0]  code_addr,
    input  logic [INSTR_W-1:0] code_data,
    output logic [INSTR_W-1:0] ir,
    output logic [ADDR_W-1:0]  ir_pc,
    output logic               ir_valid,
    input  logic               ir_ready,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_addr,
`ifdef YASAC_FETCH_CNT_EN
    output logic [15:0]        fetch_cnt,
`endif
    output logic               busy
);

    fetch_state_e       state_q, state_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0]  ir_pc_q, ir_pc_d;
    logic               valid_q, valid_d;
    logic [ADDR_W-1:0]  pc;
    logic               pc_load;
    logic               pc_inc;
    logic [ADDR_W-1:0]  pc_load_val;
    logic               xfer;

    assign xfer = valid_q & ir_ready;

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        ir_pc_d     = ir_pc_q;
        valid_d     = valid_q;
        pc_load     = 1'b0;
        pc_inc      = 1'b0;
        pc_load_val = RESET_PC;
        unique case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (start) begin
                    state_d = ST_RUN;
                    pc_load = 1'b1;
                    valid_d = 1'b0;
                end
            end
            ST_RUN: begin
                // halt wins over redirect, redirect wins over a fetch
                if (halt) begin
                    state_d = ST_HALTED;
                    valid_d = 1'b0;
                end else if (redirect) begin
                    pc_load     = 1'b1;
                    pc_load_val = redirect_addr;
                    valid_d     = 1'b0;
                end else if (!valid_q || xfer) begin
                    ir_d    = code_data;
                    ir_pc_d = pc;
                    valid_d = 1'b1;
                    pc_inc  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            ir_q    <= '0;
            ir_pc_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            ir_pc_q <= ir_pc_d;
            valid_q <= valid_d;
        end
    end

    fetch_unit_pc_counter #(
        .ADDR_W    (ADDR_W),
        .RESET_VAL (RESET_PC)
    ) u_pc (
        .clk        (clk),
        .rst_ni     (reset_n),
        .load_i     (pc_load),
        .load_val_i (pc_load_val),
        .inc_i      (pc_inc),
        .pc_o       (pc)
    );

`ifdef YASAC_FETCH_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    // transfers flushed by a same-edge redirect or halt still count
    always_comb begin
        cnt_d = cnt_q;
        if (start && state_q != ST_RUN) begin
            cnt_d = '0;
        end else if (xfer && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign fetch_cnt = cnt_q;
`endif

    assign code_addr = pc;
    assign ir        = ir_q;
    assign ir_pc     = ir_pc_q;
    assign ir_valid  = valid_q;
    assign busy      = (state_q == ST_RUN);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random stimulus
// against a cycle-level behavioural model (two instances, RESET_PC 00 and FE).
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        halt;
    logic        ir_ready;
    logic        redirect;
    logic [7:0]  redirect_addr;

    logic [7:0]  code_addr0, code_addr1;
    logic [15:0] code_data0, code_data1;
    logic [15:0] ir0, ir1;
    logic [7:0]  ir_pc0, ir_pc1;
    logic        ir_valid0, ir_valid1;
    logic        busy0, busy1;
`ifdef YASAC_FETCH_CNT_EN
    logic [15:0] cnt0, cnt1;
`endif

    logic [15:0] mem [256];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign code_data0 = mem[code_addr0];
    assign code_data1 = mem[code_addr1];

    fetch_unit u_dut0 (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .halt          (halt),
        .code_addr     (code_addr0),
        .code_data     (code_data0),
        .ir            (ir0),
        .ir_pc         (ir_pc0),
        .ir_valid      (ir_valid0),
        .ir_ready      (ir_ready),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
`ifdef YASAC_FETCH_CNT_EN
        .fetch_cnt     (cnt0),
`endif
        .busy          (busy0)
    );

    fetch_unit #(.RESET_PC(8'hFE)) u_dut1 (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .halt          (halt),
        .code_addr     (code_addr1),
        .code_data     (code_data1),
        .ir            (ir1),
        .ir_pc         (ir_pc1),
        .ir_valid      (ir_valid1),
        .ir_ready      (ir_ready),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
`ifdef YASAC_FETCH_CNT_EN
        .fetch_cnt     (cnt1),
`endif
        .busy          (busy1)
    );

    typedef struct {
        bit          run;
        bit          v;
        logic [7:0]  pc;
        logic [7:0]  ir_pc;
        logic [15:0] ir;
        int          cnt;
    } mdl_t;

    mdl_t m0, m1;

    function automatic mdl_t mstep(mdl_t m, logic [7:0] rp);
        mdl_t n = m;
        bit xfer = m.v && ir_ready;
        if (!reset_n) begin
            n.run = 0; n.v = 0; n.pc = rp;
            n.ir = '0; n.ir_pc = '0; n.cnt = 0;
        end else if (!m.run) begin
            if (start) begin
                n.run = 1; n.v = 0; n.pc = rp; n.cnt = 0;
            end
        end else begin
            if (xfer && m.cnt < 65535) n.cnt = m.cnt + 1;
            if (halt) begin
                n.run = 0; n.v = 0;
            end else if (redirect) begin
                n.pc = redirect_addr; n.v = 0;
            end else if (!m.v || xfer) begin
                n.ir = mem[m.pc]; n.ir_pc = m.pc;
                n.v = 1; n.pc = m.pc + 8'd1;
            end
        end
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        m0 = mstep(m0, 8'h00);
        m1 = mstep(m1, 8'hFE);
        #1;
        check("addr0", 32'(code_addr0), 32'(m0.pc));
        check("valid0", 32'(ir_valid0), 32'(m0.v));
        check("busy0", 32'(busy0), 32'(m0.run));
        check("irpc0", 32'(ir_pc0), 32'(m0.ir_pc));
        check("ir0", 32'(ir0), 32'(m0.ir));
        check("addr1", 32'(code_addr1), 32'(m1.pc));
        check("valid1", 32'(ir_valid1), 32'(m1.v));
        check("busy1", 32'(busy1), 32'(m1.run));
        check("irpc1", 32'(ir_pc1), 32'(m1.ir_pc));
        check("ir1", 32'(ir1), 32'(m1.ir));
`ifdef YASAC_FETCH_CNT_EN
        check("cnt0", 32'(cnt0), 32'(m0.cnt));
        check("cnt1", 32'(cnt1), 32'(m1.cnt));
`endif
    endtask

    task automatic idle_inputs();
        start = 0; halt = 0; redirect = 0; redirect_addr = '0;
    endtask

    logic [7:0] saved_pc;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h1111; mem[1] = 16'h2222;
        mem[2] = 16'h3333; mem[3] = 16'h4444;

        reset_n = 0; ir_ready = 0; idle_inputs();
        cycle(); cycle();
        check("rst_valid", 32'(ir_valid0), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_ir", 32'(ir0), 32'd0);

        // start, stream 1111/2222, stall at 2222, then 3333/4444
        reset_n = 1; start = 1; cycle();
        start = 0; ir_ready = 1;
        check("start_bubble", 32'(ir_valid0), 32'd0);
        cycle();
        check("seq_ir0", 32'(ir0), 32'h1111);
        check("seq_pc0", 32'(ir_pc0), 32'h00);
        check("seq_v0", 32'(ir_valid0), 32'd1);
        cycle();
        check("seq_ir1", 32'(ir0), 32'h2222);
        ir_ready = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("stall_ir", 32'(ir0), 32'h2222);
            check("stall_irpc", 32'(ir_pc0), 32'h01);
            check("stall_addr", 32'(code_addr0), 32'h02);
        end
        ir_ready = 1; cycle();
        check("rel_ir", 32'(ir0), 32'h3333);
        cycle();
        check("seq_ir3", 32'(ir0), 32'h4444);
        check("seq_pc3", 32'(ir_pc0), 32'h03);

        // redirect to 0x40 while valid
        redirect = 1; redirect_addr = 8'h40; cycle();
        redirect = 0;
        check("redir_bubble", 32'(ir_valid0), 32'd0);
        cycle();
        check("redir_irpc", 32'(ir_pc0), 32'h40);
        check("redir_ir", 32'(ir0), 32'(mem[64]));

        // halt with redirect: halt wins, pc holds
        saved_pc = code_addr0;
        halt = 1; redirect = 1; redirect_addr = 8'h80; cycle();
        idle_inputs();
        check("halt_busy", 32'(busy0), 32'd0);
        check("halt_valid", 32'(ir_valid0), 32'd0);
        check("halt_pc", 32'(code_addr0), 32'(saved_pc));
        redirect = 1; redirect_addr = 8'h33; cycle();
        redirect = 0;
        check("halt_ign_redir", 32'(code_addr0), 32'(saved_pc));

        // restart; FE instance wraps FE, FF, 00, 01
        start = 1; cycle();
        start = 0; cycle();
        check("restart_pc0", 32'(ir_pc0), 32'h00);
        check("wrap_fe", 32'(ir_pc1), 32'hFE);
        cycle();
        check("wrap_ff", 32'(ir_pc1), 32'hFF);
        cycle();
        check("wrap_00", 32'(ir_pc1), 32'h00);
        cycle();
        check("wrap_01", 32'(ir_pc1), 32'h01);

`ifdef YASAC_FETCH_CNT_EN
        halt = 1; cycle(); halt = 0;
        start = 1; cycle(); start = 0;
        check("cnt_clr", 32'(cnt0), 32'd0);
        for (int i = 0; i < 6; i++) cycle();
        check("cnt_5", 32'(cnt0), 32'd5);
`endif

        // reset during a stall clears everything on the same edge
        ir_ready = 0; cycle();
        reset_n = 0; cycle();
        check("rst_mid_valid", 32'(ir_valid0), 32'd0);
        check("rst_mid_ir", 32'(ir0), 32'd0);
        check("rst_mid_irpc", 32'(ir_pc0), 32'd0);
        check("rst_mid_addr", 32'(code_addr0), 32'd0);
        check("rst_mid_busy", 32'(busy0), 32'd0);
`ifdef YASAC_FETCH_CNT_EN
        check("rst_mid_cnt", 32'(cnt0), 32'd0);
`endif
        reset_n = 1;

        for (int i = 0; i < 600; i++) begin
            reset_n       = ($urandom_range(99) >= 2);
            start         = ($urandom_range(99) < 6);
            halt          = ($urandom_range(99) < 3);
            redirect      = ($urandom_range(99) < 10);
            redirect_addr = 8'($urandom);
            ir_ready      = ($urandom_range(99) < 70);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
